// File: rtl/imem_program_loader_if.sv
// imem_program_loader_if: word stream in, IMEM write port out
interface imem_program_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic       in_last;
    logic       imem_we;
    logic [9:0] imem_addr;
    logic [9:0] imem_wdata;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// imem_program_loader: streams a program into IMEM while holding the CPU in reset
module imem_program_loader #(
    parameter int DEPTH        = 35,
    parameter int HOLD_CYCLES  = 4,
    parameter int STOP_ON_HALT = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    imem_program_loader_if.slave         bus,
    output logic                         cpu_reset,
    output logic                         busy,
    output logic                         load_done,
    output logic                         overflow_err,
    output logic [9:0]                   word_count
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;

    state_t        state_q, state_d;
    logic [9:0]    word_count_q, word_count_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          imem_we_q, imem_we_d;
    logic [9:0]    imem_addr_q, imem_addr_d;
    logic [9:0]    imem_wdata_q, imem_wdata_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          busy_q, busy_d;
    logic          load_done_q, load_done_d;
    logic          overflow_err_q, overflow_err_d;
    logic          full, xfer, term;

    assign full          = word_count_q == 10'(DEPTH);
    assign bus.in_ready  = (state_q == LOAD) && !full;
    assign xfer          = bus.in_valid && bus.in_ready;
    assign term          = bus.in_last || (STOP_ON_HALT != 0 && bus.in_data[9:7] == 3'b111);

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign busy           = busy_q;
    assign load_done      = load_done_q;
    assign overflow_err   = overflow_err_q;
    assign word_count     = word_count_q;

    // Next state: accept words in LOAD, count the CPU reset hold, restart from IDLE/RUN/ERR
    always_comb begin
        state_d        = state_q;
        word_count_d   = word_count_q;
        hold_d         = hold_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        cpu_reset_d    = cpu_reset_q;
        busy_d         = busy_q;
        load_done_d    = load_done_q;
        overflow_err_d = overflow_err_q;
        case (state_q)
            LOAD: begin
                if (xfer) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_count_q;
                    imem_wdata_d = bus.in_data;
                    word_count_d = word_count_q + 10'd1;
                    if (term) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end else if (full && bus.in_valid) begin
                    state_d        = ERR;
                    overflow_err_d = 1'b1;
                    busy_d         = 1'b0;
                end
            end
            HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES)) begin
                    state_d     = RUN;
                    cpu_reset_d = 1'b0;
                    load_done_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d        = LOAD;
                    word_count_d   = '0;
                    overflow_err_d = 1'b0;
                    load_done_d    = 1'b0;
                    cpu_reset_d    = 1'b1;
                    busy_d         = 1'b1;
                end
            end
        endcase
    end

    // State registers; reset wins over start and transfers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            word_count_q   <= '0;
            hold_q         <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_reset_q    <= 1'b1;
            busy_q         <= 1'b0;
            load_done_q    <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_count_q   <= word_count_d;
            hold_q         <= hold_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            busy_q         <= busy_d;
            load_done_q    <= load_done_d;
            overflow_err_q <= overflow_err_d;
        end
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed checks of load, halt, backpressure, overflow and reset
module tb_imem_program_loader;
    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       cpu_reset, busy, load_done, overflow_err;
    logic [9:0] word_count;
    int         errors = 0;
    int         checks = 0;
    int         wr_cnt = 0;
    int         consec = 0;
    int         last_addr = -1;
    int         w0;
    int         k;
    logic       prev_we = 1'b0;
    logic [9:0] mem [0:34];
    logic       vpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0] dpat [6] = '{10'h0A1, 10'h3F0, 10'h3F1, 10'h0B2, 10'h3F2, 10'h0C3};

    imem_program_loader_if bus ();

    imem_program_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .load_done    (load_done),
        .overflow_err (overflow_err),
        .word_count   (word_count)
    );

    always #5 clock = ~clock;

    // IMEM model: capture every write strobe and flag back-to-back strobes
    always @(posedge clock) begin
        if (bus.imem_we) begin
            wr_cnt++;
            last_addr = int'(bus.imem_addr);
            if (bus.imem_addr < 10'd35) mem[bus.imem_addr] = bus.imem_wdata;
        end
        if (bus.imem_we && prev_we) consec++;
        prev_we = bus.imem_we;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_ovf", 32'(overflow_err), 0);
        chk("rst_wc", 32'(word_count), 0);
        chk("rst_we", 32'(bus.imem_we), 0);
        chk("rst_ready", 32'(bus.in_ready), 0);

        // basic load of three words
        start = 1'b1; tick(); start = 1'b0;
        chk("bl_busy", 32'(busy), 1);
        chk("bl_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.in_data = 10'h020; tick();
        chk("bl_we0", 32'(bus.imem_we), 1);
        chk("bl_addr0", 32'(bus.imem_addr), 0);
        chk("bl_data0", 32'(bus.imem_wdata), 32'h020);
        bus.in_data = 10'h031; tick();
        chk("bl_addr1", 32'(bus.imem_addr), 1);
        chk("bl_data1", 32'(bus.imem_wdata), 32'h031);
        bus.in_data = 10'h150; bus.in_last = 1'b1; tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("bl_addr2", 32'(bus.imem_addr), 2);
        chk("bl_data2", 32'(bus.imem_wdata), 32'h150);
        chk("bl_wc", 32'(word_count), 3);
        chk("bl_ready_low", 32'(bus.in_ready), 0);
        tick(); tick(); tick(); tick();
        chk("bl_hold_cpu_reset", 32'(cpu_reset), 1);
        chk("bl_hold_busy", 32'(busy), 1);
        tick();
        chk("bl_run_cpu_reset", 32'(cpu_reset), 0);
        chk("bl_run_done", 32'(load_done), 1);
        chk("bl_run_busy", 32'(busy), 0);
        tick(); tick();
        chk("bl_run_stays", 32'(load_done), 1);
        chk("bl_run_wc", 32'(word_count), 3);

        // restart from RUN
        start = 1'b1; tick(); start = 1'b0;
        chk("rs_cpu_reset", 32'(cpu_reset), 1);
        chk("rs_busy", 32'(busy), 1);
        chk("rs_wc", 32'(word_count), 0);
        chk("rs_done", 32'(load_done), 0);

        // backpressure with a stray start pulse in LOAD
        w0 = wr_cnt; consec = 0; k = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = vpat[i]; bus.in_data = dpat[i];
            bus.in_last = (i == 5); start = (i == 2);
            tick();
            chk("bp_we", 32'(bus.imem_we), 32'(vpat[i]));
            if (vpat[i]) begin
                chk("bp_addr", 32'(bus.imem_addr), 32'(k));
                chk("bp_data", 32'(bus.imem_wdata), 32'(dpat[i]));
                k++;
            end
            chk("bp_wc", 32'(word_count), 32'(k));
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; start = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("bp_done", 32'(load_done), 1);
        chk("bp_writes", 32'(wr_cnt - w0), 3);
        chk("bp_no_consec", 32'(consec), 0);

        // halt termination
        start = 1'b1; tick(); start = 1'b0;
        w0 = wr_cnt;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.in_data = 10'(i + 5); tick();
        end
        bus.in_data = 10'b1110000000; tick();
        chk("ht_ready_low", 32'(bus.in_ready), 0);
        chk("ht_wc", 32'(word_count), 10);
        chk("ht_addr", 32'(bus.imem_addr), 9);
        chk("ht_data", 32'(bus.imem_wdata), 32'h380);
        bus.in_data = 10'h055; tick();
        chk("ht_extra_we", 32'(bus.imem_we), 0);
        bus.in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("ht_done", 32'(load_done), 1);
        chk("ht_writes", 32'(wr_cnt - w0), 10);
        chk("ht_last_addr", 32'(last_addr), 9);
        chk("ht_mem9", 32'(mem[9]), 32'h380);
        chk("ht_mem0", 32'(mem[0]), 32'h005);
        chk("ht_wc_kept", 32'(word_count), 10);

        // overflow
        start = 1'b1; tick(); start = 1'b0;
        w0 = wr_cnt;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 35; i++) begin
            bus.in_data = 10'(i); tick();
        end
        chk("ov_wc_full", 32'(word_count), 35);
        chk("ov_ready_low", 32'(bus.in_ready), 0);
        chk("ov_addr34", 32'(bus.imem_addr), 34);
        bus.in_data = 10'h123; tick();
        chk("ov_err", 32'(overflow_err), 1);
        chk("ov_busy", 32'(busy), 0);
        chk("ov_cpu_reset", 32'(cpu_reset), 1);
        chk("ov_no_we", 32'(bus.imem_we), 0);
        chk("ov_wc", 32'(word_count), 35);
        bus.in_valid = 1'b0;
        tick(); tick();
        chk("ov_sticky", 32'(overflow_err), 1);
        chk("ov_writes", 32'(wr_cnt - w0), 35);
        chk("ov_last_addr", 32'(last_addr), 34);
        chk("ov_mem34", 32'(mem[34]), 32'h022);
        start = 1'b1; tick(); start = 1'b0;
        chk("ov_clear", 32'(overflow_err), 0);
        chk("ov_restart_busy", 32'(busy), 1);
        chk("ov_restart_wc", 32'(word_count), 0);

        // mid-load reset with a transfer pending
        bus.in_valid = 1'b1;
        bus.in_data = 10'h011; tick();
        bus.in_data = 10'h012; tick();
        chk("mr_wc2", 32'(word_count), 2);
        reset = 1'b1; bus.in_data = 10'h013; tick();
        reset = 1'b0; bus.in_valid = 1'b0;
        chk("mr_we", 32'(bus.imem_we), 0);
        chk("mr_addr", 32'(bus.imem_addr), 0);
        chk("mr_wdata", 32'(bus.imem_wdata), 0);
        chk("mr_cpu_reset", 32'(cpu_reset), 1);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(load_done), 0);
        chk("mr_ovf", 32'(overflow_err), 0);
        chk("mr_wc", 32'(word_count), 0);
        chk("mr_ready", 32'(bus.in_ready), 0);
        start = 1'b1; tick(); start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 10'h0AA; tick();
        bus.in_valid = 1'b0;
        chk("mr_new_we", 32'(bus.imem_we), 1);
        chk("mr_new_addr", 32'(bus.imem_addr), 0);
        chk("mr_new_data", 32'(bus.imem_wdata), 32'h0AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
